// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised FIFO.
package sync_fifo_param_pkg;

  localparam int unsigned DEF_DATA_W    = 8;
  localparam int unsigned DEF_DEPTH     = 8;
  localparam int unsigned DEF_AE_LEVEL  = 2;
  localparam int unsigned DEF_AF_MARGIN = 2;

  // Ceiling log2, used to size pointers and the occupancy counter.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r = r + 1;
    return r;
  endfunction

  // True when v is a non-zero power of two.
  function automatic logic is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
module fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage write; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Read register: cleared by reset, holds whenever no read is issued.
  always_ff @(posedge clk) begin
    if (!rst_n)  r_rdata <= '0;
    else if (re) r_rdata <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, thresholds and error pulses.
module sync_fifo_param
  import sync_fifo_param_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned AF_LEVEL = DEPTH - DEF_AF_MARGIN,
  parameter int unsigned AE_LEVEL = DEF_AE_LEVEL
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wen,
  input  logic                   ren,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      dout,
  output logic                   dout_valid,
  output logic [clog2(DEPTH):0]  count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int unsigned AW    = clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_CNT   = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] AE_CNT   = CNT_W'(AE_LEVEL);

  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_dout_valid;
  logic              r_overflow;
  logic              r_underflow;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_we;
  logic              w_re;
  logic [DATA_W-1:0] w_rdata;

  // Configuration sanity check at elaboration/simulation start.
  initial begin
    if (!is_pow2(DEPTH) || DEPTH < 2)
      $error("sync_fifo_param: DEPTH=%0d must be a power of two >= 2", DEPTH);
    if (AF_LEVEL > DEPTH)
      $error("sync_fifo_param: AF_LEVEL=%0d exceeds DEPTH=%0d", AF_LEVEL, DEPTH);
    if (DATA_W < 1)
      $error("sync_fifo_param: DATA_W must be >= 1");
  end

  // Accept decisions from pre-edge state; a read frees a slot for a same-cycle write.
  always_comb begin
    w_rd_acc = ren && (r_count != '0);
    w_wr_acc = wen && ((r_count != FULL_CNT) || w_rd_acc);
  end

  // Reset dominates any request reaching the array.
  assign w_we = w_wr_acc & rst_n;
  assign w_re = w_rd_acc & rst_n;

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_mem (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (w_we),
    .waddr  (r_wptr),
    .wdata  (din),
    .re     (w_re),
    .raddr  (r_rptr),
    .rdata  (w_rdata)
  );

  // Pointers, occupancy and one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_dout_valid <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
    end else begin
      if (w_wr_acc) r_wptr <= r_wptr + AW'(1);
      if (w_rd_acc) r_rptr <= r_rptr + AW'(1);
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      r_dout_valid <= w_rd_acc;
      r_overflow   <= wen & ~w_wr_acc;
      r_underflow  <= ren & ~w_rd_acc;
    end
  end

  assign dout         = w_rdata;
  assign dout_valid   = r_dout_valid;
  assign count        = r_count;
  assign full         = (r_count == FULL_CNT);
  assign empty        = (r_count == '0);
  assign almost_full  = (r_count >= AF_CNT);
  assign almost_empty = (r_count <= AE_CNT);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
